// File: rtl/elastic_pipeline_chain.sv
// elastic_pipeline_chain
//   A STAGES-deep chain of payload registers, each with a valid bit, plus
//   valid/ready backpressure, per-stage flush, and occupancy/discard counters.
//   Empty stages ahead of a stall keep accepting, so bubbles collapse toward
//   the output.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high; clears all state
//   inValid      upstream offers inData
//   inReady      chain accepts inData this cycle
//   inData       payload in
//   outValid     stage STAGES-1 holds a live entry
//   outReady     downstream consumes outData this cycle
//   outData      payload of stage STAGES-1, valid or not
//   flush        bit k discards the entry held in stage k this cycle
//   occupancy    number of valid stages (registered)
//   discardCount live entries killed by flush, saturating
module elastic_pipeline_chain #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic [DATA_WIDTH-1:0]        inData,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [DATA_WIDTH-1:0]        outData,
  input  logic [STAGES-1:0]            flush,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic [CNT_WIDTH-1:0]         discardCount
);

  localparam int OCC_WIDTH = $clog2(STAGES + 1);
  localparam int SUM_WIDTH = CNT_WIDTH + OCC_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [STAGES-1:0]     valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q [STAGES];
  logic [DATA_WIDTH-1:0] data_d [STAGES];
  logic [OCC_WIDTH-1:0]  occ_q, occ_d;
  logic [CNT_WIDTH-1:0]  disc_q, disc_d;

  logic [STAGES-1:0]     live;
  logic [STAGES:0]       rdy;
  logic [STAGES-1:0]     src_valid;
  logic [DATA_WIDTH-1:0] src_data [STAGES];
  logic [OCC_WIDTH-1:0]  kill_cnt;
  logic [SUM_WIDTH-1:0]  disc_sum;

  always_comb begin
    // A flushed entry counts as an empty slot in the same cycle, so it
    // neither blocks the stage behind it nor leaves through the output.
    live = valid_q & ~flush;

    rdy = '0;
    rdy[STAGES] = outReady;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = ~live[k] | rdy[k+1];
    end

    src_valid = '0;
    for (int k = 0; k < STAGES; k++) begin
      src_data[k] = '0;
    end
    src_valid[0] = inValid;
    src_data[0]  = inData;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = live[k-1];
      src_data[k]  = data_q[k-1];
    end

    valid_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      data_d[k] = data_q[k];
      if (rdy[k]) begin
        valid_d[k] = src_valid[k];
        if (src_valid[k]) begin
          data_d[k] = src_data[k];
        end
      end else begin
        // Stalled stage is necessarily live, so this simply holds it.
        valid_d[k] = live[k];
      end
    end

    occ_d    = '0;
    kill_cnt = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ_d    = occ_d + OCC_WIDTH'(valid_d[k]);
      kill_cnt = kill_cnt + OCC_WIDTH'(valid_q[k] & flush[k]);
    end

    // Widened add so the saturation test sees the true sum.
    disc_sum = SUM_WIDTH'(disc_q) + SUM_WIDTH'(kill_cnt);
    if (disc_sum > SUM_WIDTH'(CNT_MAX)) begin
      disc_d = CNT_MAX;
    end else begin
      disc_d = disc_sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      occ_q   <= '0;
      disc_q  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      disc_q  <= disc_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign inReady      = rdy[0];
  assign outValid     = live[STAGES-1];
  assign outData      = data_q[STAGES-1];
  assign occupancy    = occ_q;
  assign discardCount = disc_q;

endmodule

// File: tb/tb_elastic_pipeline_chain.sv
// Bench for elastic_pipeline_chain: directed scenarios plus a randomized run
// checked against a slot-movement model of the chain.
module tb_elastic_pipeline_chain;

  logic        clock = 1'b0;
  logic        rst = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [3:0]  flush = '0;
  logic [2:0]  occ;
  logic [15:0] disc;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [7:0]  in_data2 = '0;
  logic        out_valid2;
  logic        out_ready2 = 1'b0;
  logic [7:0]  out_data2;
  logic [3:0]  flush2 = '0;
  logic [2:0]  occ2;
  logic [1:0]  disc2;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clock = ~clock;

  elastic_pipeline_chain #(.DATA_WIDTH(8), .STAGES(4), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset(rst),
    .inValid(in_valid), .inReady(in_ready), .inData(in_data),
    .outValid(out_valid), .outReady(out_ready), .outData(out_data),
    .flush(flush), .occupancy(occ), .discardCount(disc)
  );

  elastic_pipeline_chain #(.DATA_WIDTH(8), .STAGES(4), .CNT_WIDTH(2)) dut_sat (
    .clock(clock), .reset(rst),
    .inValid(in_valid2), .inReady(in_ready2), .inData(in_data2),
    .outValid(out_valid2), .outReady(out_ready2), .outData(out_data2),
    .flush(flush2), .occupancy(occ2), .discardCount(disc2)
  );

  // Reference model: each slot holds (valid, data); an entry moves forward
  // when the slot ahead is empty or is itself being vacated this cycle.
  logic [3:0] mv = '0;
  logic [7:0] md [4] = '{default: 8'h00};
  logic [3:0] ml, mov;
  int         mdisc = 0;
  logic       exp_ov, exp_ir;
  logic [7:0] exp_od;
  int         exp_occ, exp_disc;

  task automatic model_eval();
    ml = mv & ~flush;
    mov[3] = ml[3] & out_ready;
    for (int k = 2; k >= 0; k--) mov[k] = ml[k] & (~ml[k+1] | mov[k+1]);
    exp_ov = ml[3];
    exp_od = md[3];
    exp_ir = ~ml[0] | mov[0];
    exp_occ = 0;
    for (int k = 0; k < 4; k++) exp_occ += int'(mv[k]);
    exp_disc = mdisc;
  endtask

  task automatic model_next();
    int kills;
    if (rst) begin
      mv = '0;
      for (int k = 0; k < 4; k++) md[k] = 8'h00;
      mdisc = 0;
      return;
    end
    kills = 0;
    for (int k = 0; k < 4; k++) kills += int'(mv[k] & flush[k]);
    mdisc = (mdisc + kills > 65535) ? 65535 : mdisc + kills;
    for (int k = 3; k >= 1; k--) begin
      if (mov[k-1]) begin
        mv[k] = 1'b1;
        md[k] = md[k-1];
      end else begin
        mv[k] = ml[k] & ~mov[k];
      end
    end
    if (in_valid && exp_ir) begin
      mv[0] = 1'b1;
      md[0] = in_data;
    end else begin
      mv[0] = ml[0] & ~mov[0];
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_eval();
    model_next();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; flush2 = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    n_cmp++;
    if (out_data !== 8'h00) begin n_mis++; $display("FAIL reset_out_data got=%h want=00", out_data); end
    n_cmp++;
    if (occ !== 3'd0) begin n_mis++; $display("FAIL reset_occ got=%0d want=0", occ); end
    n_cmp++;
    if (disc !== 16'd0) begin n_mis++; $display("FAIL reset_disc got=%0d want=0", disc); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    n_cmp++;
  endtask

  task automatic test_fill();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data = 8'(8'h10 + c);
      settle();
      if (out_valid !== (c >= 4)) begin n_mis++; $display("FAIL fill_valid c=%0d got=%0b want=%0b", c, out_valid, c >= 4); end
      n_cmp++;
      if (c >= 4) begin
        if (out_data !== 8'(8'h10 + c - 4)) begin n_mis++; $display("FAIL fill_data c=%0d got=%h want=%h", c, out_data, 8'(8'h10 + c - 4)); end
        n_cmp++;
        if (occ !== 3'd4) begin n_mis++; $display("FAIL fill_occ c=%0d got=%0d want=4", c, occ); end
        n_cmp++;
      end
      if (in_ready !== 1'b1) begin n_mis++; $display("FAIL fill_in_ready c=%0d got=%0b want=1", c, in_ready); end
      n_cmp++;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] got [$];
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_data = 8'(8'h10 + c);
      settle();
      if (in_ready !== 1'b1) begin n_mis++; $display("FAIL bp_fill_ready c=%0d got=%0b want=1", c, in_ready); end
      n_cmp++;
      tick();
    end
    in_data = 8'h55;
    for (int c = 0; c < 3; c++) begin
      settle();
      if (in_ready !== 1'b0) begin n_mis++; $display("FAIL bp_stall_ready c=%0d got=%0b want=0", c, in_ready); end
      n_cmp++;
      if (out_data !== 8'h10 || out_valid !== 1'b1) begin n_mis++; $display("FAIL bp_hold c=%0d got=%0b/%h want=1/10", c, out_valid, out_data); end
      n_cmp++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (out_valid === 1'b1) got.push_back(out_data);
      tick();
    end
    if (got.size() != 4) begin n_mis++; $display("FAIL bp_drain_count got=%0d want=4", got.size()); end
    n_cmp++;
    for (int i = 0; i < got.size() && i < 4; i++) begin
      if (got[i] !== 8'(8'h10 + i)) begin n_mis++; $display("FAIL bp_drain_order i=%0d got=%h want=%h", i, got[i], 8'(8'h10 + i)); end
      n_cmp++;
    end
  endtask

  task automatic test_bubble();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle();
      if (in_ready !== 1'b1) begin n_mis++; $display("FAIL bubble_ready c=%0d got=%0b want=1", c, in_ready); end
      n_cmp++;
      tick();
    end
    settle();
    if (out_valid !== 1'b1 || out_data !== 8'hAA) begin n_mis++; $display("FAIL bubble_head got=%0b/%h want=1/aa", out_valid, out_data); end
    n_cmp++;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = 8'(c + 1);
      settle();
      if (in_ready !== 1'b1) begin n_mis++; $display("FAIL bubble_fill_ready c=%0d got=%0b want=1", c, in_ready); end
      n_cmp++;
      tick();
    end
    settle();
    if (in_ready !== 1'b0) begin n_mis++; $display("FAIL bubble_full_ready got=%0b want=0", in_ready); end
    n_cmp++;
    if (occ !== 3'd4) begin n_mis++; $display("FAIL bubble_occ got=%0d want=4", occ); end
    n_cmp++;
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    logic [7:0] got [$];
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_data = 8'(8'hA0 + c);
      tick();
    end
    in_valid = 1'b0; flush = 4'b0011;
    tick();
    flush = '0;
    settle();
    if (disc !== 16'd2) begin n_mis++; $display("FAIL flush_disc got=%0d want=2", disc); end
    n_cmp++;
    if (occ !== 3'd2) begin n_mis++; $display("FAIL flush_occ got=%0d want=2", occ); end
    n_cmp++;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (out_valid === 1'b1) got.push_back(out_data);
      tick();
    end
    if (got.size() != 2) begin n_mis++; $display("FAIL flush_drain_count got=%0d want=2", got.size()); end
    n_cmp++;
    for (int i = 0; i < got.size() && i < 2; i++) begin
      if (got[i] !== 8'(8'hA0 + i)) begin n_mis++; $display("FAIL flush_drain_order i=%0d got=%h want=%h", i, got[i], 8'(8'hA0 + i)); end
      n_cmp++;
    end
  endtask

  task automatic test_saturation();
    int want;
    do_reset();
    in_valid2 = 1'b1; out_ready2 = 1'b1; flush2 = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      in_data2 = 8'(i);
      settle();
      if (in_ready2 !== 1'b1) begin n_mis++; $display("FAIL sat_in_ready i=%0d got=%0b want=1", i, in_ready2); end
      n_cmp++;
      if (out_valid2 !== 1'b0) begin n_mis++; $display("FAIL sat_out_valid i=%0d got=%0b want=0", i, out_valid2); end
      n_cmp++;
      tick();
      #1;
      want = (i > 3) ? 3 : i;
      if (disc2 !== 2'(want)) begin n_mis++; $display("FAIL sat_disc i=%0d got=%0d want=%0d", i, disc2, want); end
      n_cmp++;
    end
    in_valid2 = 1'b0; flush2 = '0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = 8'(8'h31 + c);
      tick();
    end
    in_valid = 1'b0; flush = 4'b0001;
    tick();
    flush = '0;
    settle();
    if (disc !== 16'd1 || out_data !== 8'h31) begin n_mis++; $display("FAIL mid_pre got=%0d/%h want=1/31", disc, out_data); end
    n_cmp++;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    settle();
    if (out_valid !== 1'b0 || occ !== 3'd0 || disc !== 16'd0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL mid_reset got ov=%0b occ=%0d disc=%0d od=%h ir=%0b want 0/0/0/00/1", out_valid, occ, disc, out_data, in_ready);
    end
    n_cmp++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      rst       = ($urandom_range(0, 149) == 0);
      settle();
      if (out_valid !== exp_ov) begin n_mis++; $display("FAIL rnd_out_valid c=%0d got=%0b want=%0b", c, out_valid, exp_ov); end
      n_cmp++;
      if (out_data !== exp_od) begin n_mis++; $display("FAIL rnd_out_data c=%0d got=%h want=%h", c, out_data, exp_od); end
      n_cmp++;
      if (in_ready !== exp_ir) begin n_mis++; $display("FAIL rnd_in_ready c=%0d got=%0b want=%0b", c, in_ready, exp_ir); end
      n_cmp++;
      if (occ !== 3'(exp_occ)) begin n_mis++; $display("FAIL rnd_occ c=%0d got=%0d want=%0d", c, occ, exp_occ); end
      n_cmp++;
      if (disc !== 16'(exp_disc)) begin n_mis++; $display("FAIL rnd_disc c=%0d got=%0d want=%0d", c, disc, exp_disc); end
      n_cmp++;
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; flush = '0;
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_fill();
    test_backpressure();
    test_bubble();
    test_flush();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
